// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants, field widths, divider FSM states and a packing helper.
package fp_pkg;

    localparam int unsigned SIGN_W   = 1;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned FRAC_W   = 23;
    localparam int unsigned MANT_W   = FRAC_W + 1;
    localparam int unsigned WORD_W   = SIGN_W + EXP_W + FRAC_W;
    localparam int unsigned EXPD_W   = 10;
    localparam int unsigned REM_W    = MANT_W + 2;
    localparam int unsigned Q_W      = MANT_W + 1;

    localparam int unsigned      EXP_BIAS = 127;
    localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
    localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, DIVIDE, PACK} div_state_e;

    function automatic logic [WORD_W-1:0] fp_pack(input logic s, input logic [EXP_W-1:0] e,
                                                  input logic [FRAC_W-1:0] f);
        return {s, e, f};
    endfunction

endpackage

// File: rtl/fp_divider_if.sv
// Start/done handshake and operand/result bundle of the sequential FP divider.
interface fp_divider_if;
    import fp_pkg::*;

    logic              start;
    logic [WORD_W-1:0] A;
    logic [WORD_W-1:0] B;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] quot;
    logic              exception;
    logic              overflow;
    logic              underflow;

    modport master (output start, A, B,
                    input  busy, done, quot, exception, overflow, underflow);
    modport slave  (input  start, A, B,
                    output busy, done, quot, exception, overflow, underflow);
endinterface

// File: rtl/fp_unpack.sv
// Splits a single-precision word into sign/exponent/mantissa and classifies it.
// Denormals are flushed to zero; the hidden bit is always prepended.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    output logic              sign,
    output logic [EXP_W-1:0]  exp_f,
    output logic [MANT_W-1:0] mant,
    output logic              is_zero,
    output logic              is_inf,
    output logic              is_nan
);

    logic [FRAC_W-1:0] frac;

    always_comb begin
        sign    = x[WORD_W-1];
        exp_f   = x[WORD_W-2 -: EXP_W];
        frac    = x[FRAC_W-1:0];
        mant    = {1'b1, frac};
        is_zero = (exp_f == '0);
        is_inf  = (exp_f == EXP_MAX) && (frac == '0);
        is_nan  = (exp_f == EXP_MAX) && (frac != '0);
    end

endmodule

// File: rtl/fp_divider.sv
// Sequential single-precision divider: restoring mantissa division, one quotient bit per clock,
// truncating result, fixed 27-cycle latency for every operand class.
module fp_divider
    import fp_pkg::*;
#(
    parameter int unsigned ITER = 25
) (
    input  logic        clk,
    input  logic        reset,
    fp_divider_if.slave io
);

    localparam int unsigned CNT_W = $clog2(ITER);

    logic              a_sign, b_sign;
    logic [EXP_W-1:0]  a_exp, b_exp;
    logic [MANT_W-1:0] a_mant, b_mant;
    logic              a_zero, a_inf, a_nan;
    logic              b_zero, b_inf, b_nan;

    fp_unpack u_unpack_a (.x(io.A), .sign(a_sign), .exp_f(a_exp), .mant(a_mant),
                          .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan));
    fp_unpack u_unpack_b (.x(io.B), .sign(b_sign), .exp_f(b_exp), .mant(b_mant),
                          .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan));

    div_state_e               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [REM_W-1:0]         rem_q, rem_d;
    logic [MANT_W-1:0]        mb_q, mb_d;
    logic [Q_W-1:0]           q_q, q_d;
    logic                     sign_q, sign_d;
    logic signed [EXPD_W-1:0] ediff_q, ediff_d;
    logic                     special_q, special_d;
    logic                     spec_exc_q, spec_exc_d;
    logic [WORD_W-1:0]        spec_word_q, spec_word_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [WORD_W-1:0]        quot_q, quot_d;
    logic                     exc_q, exc_d;
    logic                     ovf_q, ovf_d;
    logic                     unf_q, unf_d;

    logic                     sign_c;
    logic                     nan_c;
    logic [REM_W-1:0]         rem_sub_c;
    logic                     qbit_c;
    logic signed [EXPD_W-1:0] e_c;
    logic [FRAC_W-1:0]        frac_c;

    // Capture-time classification and per-step restoring subtraction
    always_comb begin
        sign_c    = a_sign ^ b_sign;
        nan_c     = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
        qbit_c    = (rem_q >= {2'b00, mb_q});
        rem_sub_c = qbit_c ? (rem_q - {2'b00, mb_q}) : rem_q;
        e_c       = ediff_q + (q_q[Q_W-1] ? EXPD_W'(EXP_BIAS) : EXPD_W'(EXP_BIAS - 1));
        frac_c    = q_q[Q_W-1] ? q_q[Q_W-2:1] : q_q[Q_W-3:0];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        mb_d        = mb_q;
        q_d         = q_q;
        sign_d      = sign_q;
        ediff_d     = ediff_q;
        special_d   = special_q;
        spec_exc_d  = spec_exc_q;
        spec_word_d = spec_word_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quot_d      = quot_q;
        exc_d       = exc_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;

        case (state_q)
            IDLE: begin
                if (io.start) begin
                    state_d     = DIVIDE;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    rem_d       = {2'b00, a_mant};
                    mb_d        = b_mant;
                    q_d         = '0;
                    sign_d      = sign_c;
                    ediff_d     = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp});
                    special_d   = 1'b1;
                    spec_exc_d  = 1'b1;
                    spec_word_d = '0;
                    if (nan_c) begin
                        spec_word_d = QNAN;
                    end else if (a_inf || b_zero) begin
                        spec_word_d = fp_pack(sign_c, EXP_MAX, '0);
                    end else if (b_inf) begin
                        spec_word_d = fp_pack(sign_c, '0, '0);
                    end else if (a_zero) begin
                        spec_word_d = fp_pack(sign_c, '0, '0);
                        spec_exc_d  = 1'b0;
                    end else begin
                        special_d   = 1'b0;
                        spec_exc_d  = 1'b0;
                    end
                end
            end

            DIVIDE: begin
                q_d   = {q_q[Q_W-2:0], qbit_c};
                rem_d = rem_sub_c << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = PACK;
                end
            end

            PACK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                if (special_q) begin
                    quot_d = spec_word_q;
                    exc_d  = spec_exc_q;
                end else begin
                    exc_d = 1'b0;
                    if (e_c >= $signed(EXPD_W'(EXP_MAX))) begin
                        quot_d = fp_pack(sign_q, EXP_MAX, '0);
                        ovf_d  = 1'b1;
                    end else if (e_c <= $signed(EXPD_W'(0))) begin
                        quot_d = fp_pack(sign_q, '0, '0);
                        unf_d  = 1'b1;
                    end else begin
                        quot_d = fp_pack(sign_q, e_c[EXP_W-1:0], frac_c);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            mb_q        <= '0;
            q_q         <= '0;
            sign_q      <= 1'b0;
            ediff_q     <= '0;
            special_q   <= 1'b0;
            spec_exc_q  <= 1'b0;
            spec_word_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quot_q      <= '0;
            exc_q       <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            mb_q        <= mb_d;
            q_q         <= q_d;
            sign_q      <= sign_d;
            ediff_q     <= ediff_d;
            special_q   <= special_d;
            spec_exc_q  <= spec_exc_d;
            spec_word_q <= spec_word_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quot_q      <= quot_d;
            exc_q       <= exc_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign io.busy      = busy_q;
    assign io.done      = done_q;
    assign io.quot      = quot_q;
    assign io.exception = exc_q;
    assign io.overflow  = ovf_q;
    assign io.underflow = unf_q;

endmodule

// File: tb/tb_fp_divider.sv
// Directed-vector bench for fp_divider: latency, rounding, range flags, specials,
// back-to-back start, and reset abort.
module tb_fp_divider;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    fp_divider_if dif ();

    fp_divider #(.ITER(25)) dut (.clk(clk), .reset(reset), .io(dif));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] flags();
        return 32'({dif.exception, dif.overflow, dif.underflow});
    endfunction

    // One division from IDLE; operands are scrambled after capture to prove they were latched
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want_q, input logic [2:0] want_f);
        int n;
        dif.A     = a;
        dif.B     = b;
        dif.start = 1'b1;
        @(posedge clk); #1;
        n         = 1;
        dif.start = 1'b0;
        dif.A     = ~a;
        dif.B     = ~b;
        check({tag, "_busy"}, 32'(dif.busy), 32'd1);
        while (!dif.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"},   32'(n), 32'd27);
        check({tag, "_quot"},  dif.quot, want_q);
        check({tag, "_flags"}, flags(), 32'(want_f));
        check({tag, "_idle"},  32'(dif.busy), 32'd0);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(dif.done), 32'd0);
        check({tag, "_hold"},  dif.quot, want_q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] va[3];
        logic [31:0] vb[3];
        logic [31:0] vq[3];
        int n;
        int k;
        int seen;

        reset     = 1'b1;
        dif.start = 1'b0;
        dif.A     = '0;
        dif.B     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  32'(dif.busy), 32'd0);
        check("rst_done",  32'(dif.done), 32'd0);
        check("rst_quot",  dif.quot,      32'd0);
        check("rst_flags", flags(),       32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_div("six_by_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000);
        do_div("one_third",  32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 3'b000);
        do_div("neg",        32'hC120_0000, 32'h4080_0000, 32'hC020_0000, 3'b000);
        do_div("ovf",        32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 3'b010);
        do_div("unf",        32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 3'b001);
        do_div("div_zero",   32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 3'b100);
        do_div("zero_zero",  32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100);
        do_div("inf_inf",    32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 3'b100);
        do_div("zero_fin",   32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 3'b000);

        // start held high; operands are valid only in the done cycle, garbage otherwise
        va = '{32'h40C0_0000, 32'h3F80_0000, 32'hC120_0000};
        vb = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        vq = '{32'h4040_0000, 32'h3EAA_AAAA, 32'hC020_0000};
        dif.A     = va[0];
        dif.B     = vb[0];
        dif.start = 1'b1;
        n = 0;
        k = 0;
        for (int cyc = 0; cyc < 120 && k < 3; cyc++) begin
            @(posedge clk); #1;
            n++;
            if (dif.done) begin
                check("b2b_quot", dif.quot, vq[k]);
                check("b2b_lat",  32'(n),   32'd27);
                k++;
                n = 0;
                if (k < 3) begin
                    dif.A = va[k];
                    dif.B = vb[k];
                end else begin
                    dif.start = 1'b0;
                end
            end else begin
                dif.A = $urandom;
                dif.B = $urandom;
            end
        end
        check("b2b_count", 32'(k), 32'd3);
        @(posedge clk); #1;
        check("b2b_pulse", 32'(dif.done), 32'd0);
        check("b2b_idle",  32'(dif.busy), 32'd0);

        // Abort at the 10th cycle of a divide
        dif.A     = 32'h40C0_0000;
        dif.B     = 32'h4000_0000;
        dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_busy_pre", 32'(dif.busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy",  32'(dif.busy), 32'd0);
        check("abort_done",  32'(dif.done), 32'd0);
        check("abort_quot",  dif.quot,      32'd0);
        check("abort_flags", flags(),       32'd0);
        reset = 1'b0;
        seen  = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            if (dif.done) seen++;
        end
        check("abort_silent", 32'(seen), 32'd0);

        do_div("post_abort", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
